// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path: geometry of the
// register file and the fixed indices of the writeback requesters.
package regfile_pkg;

   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 32;
   localparam int REG_COUNT = 32;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   localparam int WB_ALU = 0;
   localparam int WB_MEM = 1;
   localparam int WB_COP = 2;

   // Pointer width for an n-way arbiter, never narrower than one bit.
   function automatic int ptrWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle: per-requester req/index/data plus the shared
// stall and the one-hot ack returned by the arbiter.
interface regfile_write_arbiter_if #(
   parameter int N_REQ  = 3,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);

   logic                      hold;
   logic [N_REQ-1:0]          req;
   logic [N_REQ*ADDR_W-1:0]   reqReg;
   logic [N_REQ*DATA_W-1:0]   reqData;
   logic [N_REQ-1:0]          ack;

   modport master (output hold, output req, output reqReg, output reqData, input ack);
   modport slave  (input hold, input req, input reqReg, input reqData, output ack);

endinterface

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter; the caller owns the pointer so the same
// block can serve any request bus that needs rotating priority.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int PTR_W = regfile_pkg::ptrWidth(N)
) (
   input  logic [N-1:0]     req,
   input  logic             enable,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] grantIdx
);

   // Scan upward from the pointer with wraparound; the first hit wins.
   always_comb begin
      int               idx;
      logic             found;
      logic [PTR_W-1:0] sel;
      grant    = '0;
      grantIdx = '0;
      found    = 1'b0;
      idx      = 0;
      sel      = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         sel = PTR_W'(idx);
         if (enable && !found && req[sel]) begin
            found     = 1'b1;
            grant[sel] = 1'b1;
            grantIdx  = sel;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port among writeback sources
// and registers the winning write onto writeEnable/regWrite/writeData.
module regfile_write_arbiter #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = regfile_pkg::DATA_W,
   parameter int ADDR_W = regfile_pkg::ADDR_W
) (
   input  logic                 clock,
   input  logic                 reset,
   regfile_write_arbiter_if.slave wb,
   output logic                 writeEnable,
   output logic [ADDR_W-1:0]    regWrite,
   output logic [DATA_W-1:0]    writeData
);

   import regfile_pkg::*;

   localparam int PTR_W = ptrWidth(N_REQ);

   logic [PTR_W-1:0]  rrPtr;
   logic [PTR_W-1:0]  grantIdx;
   logic [PTR_W-1:0]  nextPtr;
   logic [N_REQ-1:0]  grant;
   logic              transfer;
   logic [ADDR_W-1:0] winReg;
   logic [DATA_W-1:0] winData;

   // Reset suppresses the grant so no requester sees an ack it cannot complete.
   rr_arbiter #(
      .N     (N_REQ),
      .PTR_W (PTR_W)
   ) uArb (
      .req      (wb.req),
      .enable   (!wb.hold && !reset),
      .ptr      (rrPtr),
      .grant    (grant),
      .grantIdx (grantIdx)
   );

   assign wb.ack   = grant;
   assign transfer = |(wb.req & grant);
   assign nextPtr  = (int'(grantIdx) == N_REQ - 1) ? '0 : grantIdx + 1'b1;

   always_comb begin
      winReg  = '0;
      winData = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            winReg  = wb.reqReg[i*ADDR_W +: ADDR_W];
            winData = wb.reqData[i*DATA_W +: DATA_W];
         end
      end
   end

   // Writes to r0 still complete the handshake and rotate priority, but never strobe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rrPtr       <= '0;
         writeEnable <= 1'b0;
         regWrite    <= '0;
         writeData   <= '0;
      end else begin
         writeEnable <= transfer && (winReg != ADDR_W'(REG_ZERO));
         if (transfer) begin
            rrPtr     <= nextPtr;
            regWrite  <= winReg;
            writeData <= winData;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: acks are checked in the grant
// cycle, expected register writes go through a scoreboard one cycle behind.
module tb_regfile_write_arbiter;

   import regfile_pkg::*;

   typedef struct {
      logic        we;
      logic [4:0]  rg;
      logic [31:0] data;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        writeEnable;
   logic [4:0]  regWrite;
   logic [31:0] writeData;

   wr_t         sb[$];
   logic [4:0]  prevReg  = '0;
   logic [31:0] prevData = '0;
   int          checks = 0;
   int          passes = 0;

   logic [31:0] rf [32] = '{default: '0};

   regfile_write_arbiter_if #(.N_REQ(3), .ADDR_W(5), .DATA_W(32)) wb();

   regfile_write_arbiter #(.N_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
      .clock       (clock),
      .reset       (reset),
      .wb          (wb),
      .writeEnable (writeEnable),
      .regWrite    (regWrite),
      .writeData   (writeData)
   );

   always #5 clock = ~clock;

   // Register file model that commits whatever the arbiter strobes.
   always @(posedge clock) begin
      if (!reset && writeEnable) rf[regWrite] <= writeData;
   end

   task automatic advance();
      @(posedge clock);
      #1;
   endtask

   task automatic setSrc(input int i, input logic [4:0] r, input logic [31:0] d);
      wb.reqReg[i*5 +: 5]    = r;
      wb.reqData[i*32 +: 32] = d;
   endtask

   task automatic pushExpected(input logic [2:0] expAck);
      wr_t e;
      e.we   = 1'b0;
      e.rg   = prevReg;
      e.data = prevData;
      for (int i = 0; i < 3; i++) begin
         if (expAck[i]) begin
            e.rg   = wb.reqReg[i*5 +: 5];
            e.data = wb.reqData[i*32 +: 32];
            e.we   = (e.rg != 5'd0);
         end
      end
      prevReg  = e.rg;
      prevData = e.data;
      sb.push_back(e);
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      #1;
      advance();
      reset = 1'b0;
      sb.delete();
      prevReg  = '0;
      prevData = '0;
   endtask

   task automatic test_reset();
      wr_t e;
      logic [2:0] reqTab[2] = '{3'b001, 3'b000};
      logic [2:0] expTab[2] = '{3'b001, 3'b000};
      wb.hold = 1'b0;
      wb.req  = 3'b111;
      setSrc(WB_ALU, 5'd1, 32'd11);
      setSrc(WB_MEM, 5'd5, 32'd55);
      setSrc(WB_COP, 5'd3, 32'd33);
      advance();
      advance();
      checks++;
      if (wb.ack !== 3'b000) $display("[TB] FAIL reset_ack: ack=%b expected 000", wb.ack);
      else passes++;
      checks++;
      if ({writeEnable, regWrite, writeData} !== 38'd0)
         $display("[TB] FAIL reset_outputs: we=%b reg=%0d data=%0d expected all 0", writeEnable, regWrite, writeData);
      else passes++;

      reset  = 1'b0;
      wb.req = 3'b010;
      #1;
      checks++;
      if (wb.ack !== 3'b010) $display("[TB] FAIL pre_reset_ack: ack=%b expected 010", wb.ack);
      else passes++;
      pushExpected(3'b010);
      advance();
      e = sb.pop_front();
      checks++;
      if (writeEnable !== e.we || regWrite !== e.rg || writeData !== e.data)
         $display("[TB] FAIL pre_reset_write: we=%b reg=%0d data=%0d expected we=%b reg=%0d data=%0d",
                  writeEnable, regWrite, writeData, e.we, e.rg, e.data);
      else passes++;

      // Reset lands while a write sits in the output register.
      wb.req = 3'b000;
      reset  = 1'b1;
      #1;
      checks++;
      if (writeEnable !== 1'b0 || regWrite !== 5'd0 || writeData !== 32'd0 || wb.ack !== 3'b000)
         $display("[TB] FAIL midrun_reset: we=%b reg=%0d data=%0d ack=%b expected all 0",
                  writeEnable, regWrite, writeData, wb.ack);
      else passes++;
      advance();
      reset = 1'b0;
      sb.delete();
      prevReg  = '0;
      prevData = '0;

      setSrc(WB_ALU, 5'd10, 32'd200);
      for (int c = 0; c < 2; c++) begin
         wb.req = reqTab[c];
         #1;
         checks++;
         if (wb.ack !== expTab[c]) $display("[TB] FAIL first_req_ack[%0d]: ack=%b expected %b", c, wb.ack, expTab[c]);
         else passes++;
         pushExpected(expTab[c]);
         advance();
         e = sb.pop_front();
         checks++;
         if (writeEnable !== e.we || regWrite !== e.rg || writeData !== e.data)
            $display("[TB] FAIL first_req_write[%0d]: we=%b reg=%0d data=%0d expected we=%b reg=%0d data=%0d",
                     c, writeEnable, regWrite, writeData, e.we, e.rg, e.data);
         else passes++;
      end
      checks++;
      if (rf[5] !== 32'd0 || rf[10] !== 32'd200)
         $display("[TB] FAIL reset_commit: r5=%0d r10=%0d expected r5=0 r10=200", rf[5], rf[10]);
      else passes++;
   endtask

   task automatic test_round_robin();
      wr_t e;
      logic [2:0] expTab[7] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000};
      pulseReset();
      setSrc(WB_ALU, 5'd1, 32'd100);
      setSrc(WB_MEM, 5'd2, 32'd200);
      setSrc(WB_COP, 5'd3, 32'd300);
      for (int c = 0; c < 7; c++) begin
         wb.req = (c < 6) ? 3'b111 : 3'b000;
         #1;
         checks++;
         if (wb.ack !== expTab[c]) $display("[TB] FAIL rr_ack[%0d]: ack=%b expected %b", c, wb.ack, expTab[c]);
         else passes++;
         pushExpected(expTab[c]);
         advance();
         e = sb.pop_front();
         checks++;
         if (writeEnable !== e.we || regWrite !== e.rg || writeData !== e.data)
            $display("[TB] FAIL rr_write[%0d]: we=%b reg=%0d data=%0d expected we=%b reg=%0d data=%0d",
                     c, writeEnable, regWrite, writeData, e.we, e.rg, e.data);
         else passes++;
      end
      checks++;
      if (rf[1] !== 32'd100 || rf[2] !== 32'd200 || rf[3] !== 32'd300)
         $display("[TB] FAIL rr_commit: r1=%0d r2=%0d r3=%0d expected 100/200/300", rf[1], rf[2], rf[3]);
      else passes++;
   endtask

   task automatic test_r0_filter();
      wr_t e;
      logic [2:0] reqTab[3] = '{3'b010, 3'b111, 3'b000};
      logic [2:0] expTab[3] = '{3'b010, 3'b100, 3'b000};
      setSrc(WB_MEM, 5'd0, 32'd100);
      setSrc(WB_ALU, 5'd7, 32'd70);
      setSrc(WB_COP, 5'd9, 32'd90);
      for (int c = 0; c < 3; c++) begin
         wb.req = reqTab[c];
         #1;
         checks++;
         if (wb.ack !== expTab[c]) $display("[TB] FAIL r0_ack[%0d]: ack=%b expected %b", c, wb.ack, expTab[c]);
         else passes++;
         pushExpected(expTab[c]);
         advance();
         e = sb.pop_front();
         checks++;
         if (writeEnable !== e.we || regWrite !== e.rg || writeData !== e.data)
            $display("[TB] FAIL r0_write[%0d]: we=%b reg=%0d data=%0d expected we=%b reg=%0d data=%0d",
                     c, writeEnable, regWrite, writeData, e.we, e.rg, e.data);
         else passes++;
      end
      checks++;
      if (rf[0] !== 32'd0 || rf[9] !== 32'd90)
         $display("[TB] FAIL r0_commit: r0=%0d r9=%0d expected r0=0 r9=90", rf[0], rf[9]);
      else passes++;
   endtask

   task automatic test_hold();
      wr_t e;
      logic [2:0] reqTab[6]  = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b100, 3'b000};
      logic       holdTab[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [2:0] expTab[6]  = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b100, 3'b000};
      setSrc(WB_ALU, 5'd4, 32'd40);
      setSrc(WB_COP, 5'd6, 32'd60);
      for (int c = 0; c < 6; c++) begin
         wb.req  = reqTab[c];
         wb.hold = holdTab[c];
         #1;
         checks++;
         if (wb.ack !== expTab[c]) $display("[TB] FAIL hold_ack[%0d]: ack=%b expected %b", c, wb.ack, expTab[c]);
         else passes++;
         pushExpected(expTab[c]);
         advance();
         e = sb.pop_front();
         checks++;
         if (writeEnable !== e.we || regWrite !== e.rg || writeData !== e.data)
            $display("[TB] FAIL hold_write[%0d]: we=%b reg=%0d data=%0d expected we=%b reg=%0d data=%0d",
                     c, writeEnable, regWrite, writeData, e.we, e.rg, e.data);
         else passes++;
      end
      wb.hold = 1'b0;
      checks++;
      if (rf[4] !== 32'd40 || rf[6] !== 32'd60)
         $display("[TB] FAIL hold_commit: r4=%0d r6=%0d expected 40/60", rf[4], rf[6]);
      else passes++;
   endtask

   task automatic test_fairness();
      wr_t e;
      logic [2:0] reqTab[4] = '{3'b101, 3'b101, 3'b001, 3'b000};
      logic [2:0] expTab[4] = '{3'b001, 3'b100, 3'b001, 3'b000};
      setSrc(WB_COP, 5'd31, 32'd300);
      for (int c = 0; c < 4; c++) begin
         wb.req = reqTab[c];
         setSrc(WB_ALU, 5'(8 + c), 32'(80 + c));
         #1;
         checks++;
         if (wb.ack !== expTab[c]) $display("[TB] FAIL fair_ack[%0d]: ack=%b expected %b", c, wb.ack, expTab[c]);
         else passes++;
         pushExpected(expTab[c]);
         advance();
         e = sb.pop_front();
         checks++;
         if (writeEnable !== e.we || regWrite !== e.rg || writeData !== e.data)
            $display("[TB] FAIL fair_write[%0d]: we=%b reg=%0d data=%0d expected we=%b reg=%0d data=%0d",
                     c, writeEnable, regWrite, writeData, e.we, e.rg, e.data);
         else passes++;
      end
      checks++;
      if (rf[31] !== 32'd300 || rf[8] !== 32'd80 || rf[10] !== 32'd82)
         $display("[TB] FAIL fair_commit: r31=%0d r8=%0d r10=%0d expected 300/80/82", rf[31], rf[8], rf[10]);
      else passes++;
   endtask

   initial begin
      wb.hold    = 1'b0;
      wb.req     = '0;
      wb.reqReg  = '0;
      wb.reqData = '0;
      $display("[TB] starting regfile_write_arbiter bench");
      test_reset();
      test_round_robin();
      test_r0_filter();
      test_hold();
      test_fairness();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d", passes, checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Arbitrates the register file's single write port among several writeback sources (ALU result, memory load, coprocessor/syscall return). Each source presents a destination index and data under a req/ack handshake. The block grants one per cycle round-robin, registers the winning write, and drives the register file's `writeEnable` / `regWrite` / `writeData` inputs. It sits between the writeback stage and `Reg`.

## Interface
Parameters:
- `N_REQ`, 3: number of requesters; index 0 is the ALU, 1 is the load unit, 2 is the coprocessor.
- `DATA_W`, 32: data width.
- `ADDR_W`, 5: register index width (32 registers).

Ports:
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `hold`  in  1: pipeline stall; no grant is issued while it is high.
- `req`  in  N_REQ: request from each requester; held until acked.
- `reqReg`  in  N_REQ*ADDR_W: destination index per requester; slice i is `[i*ADDR_W +: ADDR_W]`.
- `reqData`  in  N_REQ*DATA_W: write data per requester, sliced likewise.
- `ack`  out  N_REQ: one-hot grant, combinational, valid in the same cycle as `req`.
- `writeEnable`  out  1: register-file write strobe (registered).
- `regWrite`  out  ADDR_W: register-file write index (registered).
- `writeData`  out  DATA_W: register-file write data (registered).

## Operation
- **Grant.** Eligible set = `req` when `hold`=0, otherwise empty.
  - Pick the first set bit searching upward from `rrPtr`, wrapping at N_REQ-1 → 0.
  - `ack` = one-hot of the winner; all zeros if nothing is eligible.
  - At most one `ack` bit is ever high.
- **Handshake.** A transfer completes on any edge where `req[i]` & `ack[i]`.
  - Requester must keep `reqReg`/`reqData` stable while `req[i]`=1 and not acked.
  - Requester may drop `req` or present new data in the following cycle.
  - Dropping `req` without an ack is legal and leaves no state behind.
- **Pointer.** On a completed transfer, `rrPtr` ← winner+1 mod N_REQ. With no transfer, `rrPtr` holds.
- **Output register.** On each edge:
  - `writeEnable` ← transfer & (winner's `reqReg` != 0).
  - `regWrite` / `writeData` ← winner's index/data when a transfer completes; otherwise they hold their previous values.
- **Register 0.** Requests targeting r0 are acked, and the pointer advances normally, but no write strobe is issued.
- **Reset.** Asserting `reset` at any time:
  - clears `rrPtr`=0, `writeEnable`=0, `regWrite`=0, `writeData`=0;
  - discards a write latched but not yet performed by the register file.
  - `ack` is forced to 0 while `reset` is high.

## Timing
- **Latency.** Cycle t: `req[i]`=1 and `ack[i]`=1 (combinational). Edge t→t+1: output register loads. Cycle t+1: `writeEnable`=1. Edge t+1→t+2: the register file commits. A read of that register returns the new value from cycle t+2.
- **Throughput.** One write per cycle sustained. The same requester may be granted in consecutive cycles only if no other requester is pending.
- **Fairness.** With all N_REQ requests held continuously, grants rotate 0,1,2,0,… (from reset). A continuously pending requester waits at most N_REQ-1 cycles.
- **`hold` timing.** `hold` is sampled combinationally in the grant cycle. `hold` rising does not cancel a write already in the output register; that write still occurs in the next cycle.
- **Reset values of every output:** `ack`=0, `writeEnable`=0, `regWrite`=0, `writeData`=0.

## Structure
- **Shared package `regfile_pkg`:** `ADDR_W`, `DATA_W`, `REG_COUNT`=32, `REG_ZERO`=5'd0, requester index constants `WB_ALU`=0, `WB_MEM`=1, `WB_COP`=2.
- **Sub-module `rr_arbiter`:** generic N-way round-robin arbiter.
  - Inputs: `req`, `enable`, pointer state.
  - Outputs: one-hot `grant`, `grantIdx`.
  - Shared with future memory-bus arbitration.
- **Top level:** owns the slicing mux, the r0 filter and the output register.

## Test plan
- **Reset values:** assert `reset` mid-run with `writeEnable`=1 → all outputs 0 immediately; deassert → first request `req`=001, `reqReg[0]`=10, data 200 → `ack`=001 in the same cycle, `writeEnable`=1 / `regWrite`=10 / `writeData`=200 one cycle later; reading r10 returns 200 afterwards.
- **Round-robin:** hold `req`=111 for 6 cycles with data 100/200/300 to r1/r2/r3 → `ack` sequence 001,010,100,001,010,100; writes appear one cycle behind.
- **r0 filter:** `req`=010 with `reqReg[1]`=0, data 100 → `ack`=010; `writeEnable` stays 0; next grant starts from requester 2.
- **Hold:** `req`=101 with `hold`=1 for 3 cycles → `ack`=0 and no writes; `hold`=0 → `ack`=001 then 100.
- **Fairness under load:** requester 0 re-requests every cycle while requester 2 requests once → requester 2 is acked within 2 cycles and writes r31 = 300.
